// File: rtl/ntt_iterative_core.sv
// In-place iterative radix-2 NTT over Z_Q. Coefficients stream in, are stored in
// bit-reversed order, transformed one butterfly per cycle (Cooley-Tukey DIT), optionally
// scaled by N^-1 for the inverse transform, and stream out in natural order.
module ntt_iterative_core #(
  parameter int unsigned Q        = 17,
  parameter int unsigned N        = 8,
  parameter int unsigned W        = $clog2(Q),
  parameter int unsigned ROOT     = 9,
  parameter int unsigned ROOT_INV = 2,
  parameter int unsigned N_INV    = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned LOGN = $clog2(N);
  localparam int unsigned HALF = N / 2;
  localparam int unsigned TW   = LOGN - 1;
  localparam int unsigned SW   = (LOGN > 1) ? $clog2(LOGN) : 1;

  localparam logic [W-1:0]    QW        = W'(Q);
  localparam logic [2*W-1:0]  QP        = (2*W)'(Q);
  localparam logic [W-1:0]    RootW     = W'(ROOT);
  localparam logic [W-1:0]    RootInvW  = W'(ROOT_INV);
  localparam logic [W-1:0]    NInvW     = W'(N_INV);
  localparam logic [LOGN-1:0] IdxLast   = LOGN'(N - 1);
  localparam logic [LOGN-1:0] InitLast  = LOGN'(HALF - 1);
  localparam logic [TW-1:0]   BflyLast  = '1;
  localparam logic [SW-1:0]   StageLast = SW'(LOGN - 1);

  typedef enum logic [2:0] {StInit, StLoad, StCompute, StScale, StOut} state_e;

  // Full 2W-bit product reduced mod Q.
  function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = a * b;
    return W'(p % QP);
  endfunction

  function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
    return r;
  endfunction

  state_e          state;
  logic [LOGN-1:0] cnt;       // INIT table index, LOAD j, SCALE index, OUT idx
  logic [TW-1:0]   bfly;      // butterfly within stage
  logic [SW-1:0]   stage;
  logic            inv_mode;
  logic [W-1:0]    tw_acc;
  logic [W-1:0]    itw_acc;

  logic [W-1:0] mem    [N];
  logic [W-1:0] w_tab  [HALF];
  logic [W-1:0] iw_tab [HALF];

  logic [LOGN-1:0] bf_b, bf_half, bf_pos, bf_u, bf_v, cnt_inc;
  logic [TW-1:0]   bf_tw;
  logic [W-1:0]    bf_t, bf_a, bf_x, bf_new_u, bf_new_v;
  logic [W:0]      bf_sum;

  assign busy    = !reset && (state != StLoad);
  assign cnt_inc = cnt + LOGN'(1);

  // Butterfly addressing and arithmetic for the current (stage, bfly).
  always_comb begin
    bf_b     = {1'b0, bfly};
    bf_half  = LOGN'(1) << stage;
    bf_pos   = bf_b & (bf_half - LOGN'(1));
    bf_u     = ((bf_b >> stage) << (32'(stage) + 1)) | bf_pos;
    bf_v     = bf_u | bf_half;
    bf_tw    = TW'(bf_pos << (LOGN - 1 - 32'(stage)));
    bf_t     = inv_mode ? iw_tab[bf_tw] : w_tab[bf_tw];
    bf_a     = mem[bf_u];
    bf_x     = mul_mod(mem[bf_v], bf_t);
    bf_sum   = {1'b0, bf_a} + {1'b0, bf_x};
    bf_new_u = (bf_sum >= {1'b0, QW}) ? W'(bf_sum - {1'b0, QW}) : bf_sum[W-1:0];
    bf_new_v = (bf_a >= bf_x) ? (bf_a - bf_x) : W'({1'b0, bf_a} + {1'b0, QW} - {1'b0, bf_x});
  end

  // Control FSM with registered handshake/output signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StInit;
      cnt       <= '0;
      bfly      <= '0;
      stage     <= '0;
      inv_mode  <= 1'b0;
      tw_acc    <= W'(1);
      itw_acc   <= W'(1);
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        StInit: begin
          tw_acc  <= mul_mod(tw_acc, RootW);
          itw_acc <= mul_mod(itw_acc, RootInvW);
          if (cnt == InitLast) begin
            cnt      <= '0;
            state    <= StLoad;
            in_ready <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StLoad: begin
          if (in_valid && in_ready) begin
            if (cnt == '0) inv_mode <= inverse;
            if (cnt == IdxLast) begin
              cnt      <= '0;
              state    <= StCompute;
              in_ready <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        StCompute: begin
          if (bfly == BflyLast) begin
            bfly <= '0;
            if (stage == StageLast) begin
              stage <= '0;
              if (inv_mode) begin
                state <= StScale;
              end else begin
                state     <= StOut;
                out_valid <= 1'b1;
                out_data  <= mem[0];
                out_last  <= 1'b0;
              end
            end else begin
              stage <= stage + SW'(1);
            end
          end else begin
            bfly <= bfly + TW'(1);
          end
        end
        StScale: begin
          if (cnt == IdxLast) begin
            cnt       <= '0;
            state     <= StOut;
            out_valid <= 1'b1;
            out_data  <= mem[0];
            out_last  <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StOut: begin
          if (out_ready) begin
            if (cnt == IdxLast) begin
              cnt       <= '0;
              state     <= StLoad;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              cnt      <= cnt_inc;
              out_data <= mem[cnt_inc];
              out_last <= (cnt_inc == IdxLast);
            end
          end
        end
        default: state <= StInit;
      endcase
    end
  end

  // Coefficient RAM and twiddle tables; contents are don't-care across reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (state)
        StInit: begin
          w_tab[cnt[TW-1:0]]  <= tw_acc;
          iw_tab[cnt[TW-1:0]] <= itw_acc;
        end
        StLoad: begin
          if (in_valid && in_ready) mem[bit_rev(cnt)] <= in_data % QW;
        end
        StCompute: begin
          mem[bf_u] <= bf_new_u;
          mem[bf_v] <= bf_new_v;
        end
        StScale: mem[cnt] <= mul_mod(mem[cnt], NInvW);
        default: ;
      endcase
    end
  end

endmodule
